// File: rtl/alu_result_stage.sv
// Two-entry in-order skid buffer that registers ALU results, flags and op code.
// Optional macro ALU_RESULT_PARITY_EN adds a registered even-parity bit on the head word.
module alu_result_stage #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_f,
  input  logic             in_carry,
  input  logic             in_zero,
  input  logic             in_eq,
  input  logic [3:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_f,
  output logic             out_carry,
  output logic             out_zero,
  output logic             out_eq,
  output logic [3:0]       out_op,
  output logic             out_parity,
  input  logic             sticky_clr,
  output logic             carry_seen,
  output logic             zero_seen,
  output logic [CNT_W-1:0] acc_count
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state, state_nxt;
  logic             accept, pop;
  logic             load_head_in, load_head_tail, load_tail;

  // Second entry; only ever read after being written, so it needs no reset.
  logic [WIDTH-1:0] tail_f;
  logic             tail_carry, tail_zero, tail_eq;
  logic [3:0]       tail_op;

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;

  always_comb begin
    state_nxt      = state;
    load_head_in   = 1'b0;
    load_head_tail = 1'b0;
    load_tail      = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          state_nxt    = ONE;
          load_head_in = 1'b1;
        end
      end
      ONE: begin
        if (accept && pop) begin
          load_head_in = 1'b1;
        end else if (accept) begin
          state_nxt = TWO;
          load_tail = 1'b1;
        end else if (pop) begin
          state_nxt = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          state_nxt      = ONE;
          load_head_tail = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // Control registers: state plus the handshake outputs derived from next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt != TWO);
      out_valid <= (state_nxt != EMPTY);
    end
  end

  // Head entry drives the outputs directly
  always_ff @(posedge clk) begin
    if (rst) begin
      out_f     <= '0;
      out_carry <= 1'b0;
      out_zero  <= 1'b0;
      out_eq    <= 1'b0;
      out_op    <= '0;
    end else if (load_head_in) begin
      out_f     <= in_f;
      out_carry <= in_carry;
      out_zero  <= in_zero;
      out_eq    <= in_eq;
      out_op    <= in_op;
    end else if (load_head_tail) begin
      out_f     <= tail_f;
      out_carry <= tail_carry;
      out_zero  <= tail_zero;
      out_eq    <= tail_eq;
      out_op    <= tail_op;
    end
  end

  always_ff @(posedge clk) begin
    if (load_tail) begin
      tail_f     <= in_f;
      tail_carry <= in_carry;
      tail_zero  <= in_zero;
      tail_eq    <= in_eq;
      tail_op    <= in_op;
    end
  end

  // Accept counter and sticky flags; a setting accept wins over sticky_clr
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_count  <= '0;
      carry_seen <= 1'b0;
      zero_seen  <= 1'b0;
    end else begin
      if (accept) acc_count <= acc_count + CNT_ONE;
      carry_seen <= (accept & in_carry) | (carry_seen & ~sticky_clr);
      zero_seen  <= (accept & in_zero)  | (zero_seen  & ~sticky_clr);
    end
  end

`ifdef ALU_RESULT_PARITY_EN
  function automatic logic even_parity(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      out_parity <= 1'b0;
    end else if (load_head_in) begin
      out_parity <= even_parity(in_f);
    end else if (load_head_tail) begin
      out_parity <= even_parity(tail_f);
    end
  end
`else
  assign out_parity = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed-vector bench for alu_result_stage: buffering order, backpressure,
// sticky flags, counter wrap, parity and reset behaviour.
module tb_alu_result_stage;

  localparam int WIDTH = 32;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_f;
  logic             in_carry, in_zero, in_eq;
  logic [3:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_f;
  logic             out_carry, out_zero, out_eq;
  logic [3:0]       out_op;
  logic             out_parity;
  logic             sticky_clr;
  logic             carry_seen, zero_seen;
  logic [CNT_W-1:0] acc_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu_result_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_f       (in_f),
    .in_carry   (in_carry),
    .in_zero    (in_zero),
    .in_eq      (in_eq),
    .in_op      (in_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_f      (out_f),
    .out_carry  (out_carry),
    .out_zero   (out_zero),
    .out_eq     (out_eq),
    .out_op     (out_op),
    .out_parity (out_parity),
    .sticky_clr (sticky_clr),
    .carry_seen (carry_seen),
    .zero_seen  (zero_seen),
    .acc_count  (acc_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    in_valid   = 1'b0;
    in_f       = '0;
    in_carry   = 1'b0;
    in_zero    = 1'b0;
    in_eq      = 1'b0;
    in_op      = '0;
    out_ready  = 1'b0;
    sticky_clr = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    in_valid = 1'b1; in_f = 32'hDEAD_BEEF; in_carry = 1'b1; out_ready = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    in_valid = 1'b0; in_carry = 1'b0;
    vectors++; if (out_valid !== 1'b0) begin $display("FAIL reset_out_valid got %0b want 0", out_valid); miscompares++; end
    vectors++; if (in_ready !== 1'b1) begin $display("FAIL reset_in_ready got %0b want 1", in_ready); miscompares++; end
    vectors++; if (out_f !== 32'h0) begin $display("FAIL reset_out_f got %h want 0", out_f); miscompares++; end
    vectors++; if (acc_count !== 16'h0) begin $display("FAIL reset_acc_count got %h want 0", acc_count); miscompares++; end
    vectors++; if ({carry_seen, zero_seen, out_parity, out_carry} !== 4'b0) begin
      $display("FAIL reset_flags got %b want 0000", {carry_seen, zero_seen, out_parity, out_carry}); miscompares++; end
  endtask

  task automatic test_single();
    do_reset();
    in_valid = 1'b1; in_f = 32'h0000_0005; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b1) begin $display("FAIL single_valid got %0b want 1", out_valid); miscompares++; end
    vectors++; if (out_f !== 32'h5) begin $display("FAIL single_f got %h want 00000005", out_f); miscompares++; end
    vectors++; if (acc_count !== 16'd1) begin $display("FAIL single_count got %0d want 1", acc_count); miscompares++; end
    step();
    vectors++; if (out_valid !== 1'b0) begin $display("FAIL single_drain got %0b want 0", out_valid); miscompares++; end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_f = 32'hAAAA_0001;
    step();
    vectors++; if (in_ready !== 1'b1) begin $display("FAIL bp_ready_one got %0b want 1", in_ready); miscompares++; end
    in_f = 32'hAAAA_0002;
    step();
    vectors++; if (in_ready !== 1'b0) begin $display("FAIL bp_ready_two got %0b want 0", in_ready); miscompares++; end
    vectors++; if (out_f !== 32'hAAAA_0001) begin $display("FAIL bp_head got %h want aaaa0001", out_f); miscompares++; end
    in_f = 32'hAAAA_0003;
    step();
    vectors++; if (out_f !== 32'hAAAA_0001 || out_valid !== 1'b1) begin
      $display("FAIL bp_hold got f=%h v=%0b want aaaa0001 v=1", out_f, out_valid); miscompares++; end
    vectors++; if (acc_count !== 16'd2) begin $display("FAIL bp_ignored got %0d want 2", acc_count); miscompares++; end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    vectors++; if (out_f !== 32'hAAAA_0002 || out_valid !== 1'b1) begin
      $display("FAIL bp_pop1 got f=%h v=%0b want aaaa0002 v=1", out_f, out_valid); miscompares++; end
    vectors++; if (in_ready !== 1'b1) begin $display("FAIL bp_ready_after_pop got %0b want 1", in_ready); miscompares++; end
    step();
    vectors++; if (out_valid !== 1'b0) begin $display("FAIL bp_pop2 got %0b want 0", out_valid); miscompares++; end
    vectors++; if (acc_count !== 16'd2) begin $display("FAIL bp_count got %0d want 2", acc_count); miscompares++; end
  endtask

  task automatic test_back_to_back();
    do_reset();
    in_valid = 1'b1; in_f = 32'h20; out_ready = 1'b0;
    step();
    in_f = 32'h10; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    vectors++; if (out_f !== 32'h10 || out_valid !== 1'b1) begin
      $display("FAIL b2b_head got f=%h v=%0b want 00000010 v=1", out_f, out_valid); miscompares++; end
    vectors++; if (in_ready !== 1'b1) begin $display("FAIL b2b_ready got %0b want 1", in_ready); miscompares++; end
    step();
    vectors++; if (out_valid !== 1'b0) begin $display("FAIL b2b_drain got %0b want 0", out_valid); miscompares++; end
  endtask

  task automatic test_sticky();
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1; in_carry = 1'b1; sticky_clr = 1'b1;
    step();
    vectors++; if (carry_seen !== 1'b1 || zero_seen !== 1'b0) begin
      $display("FAIL sticky_set_wins got c=%0b z=%0b want c=1 z=0", carry_seen, zero_seen); miscompares++; end
    in_valid = 1'b0; in_carry = 1'b0;
    step();
    vectors++; if (carry_seen !== 1'b0) begin $display("FAIL sticky_clear got %0b want 0", carry_seen); miscompares++; end
    sticky_clr = 1'b0;
    in_valid = 1'b1; in_f = '0; in_zero = 1'b1; in_eq = 1'b1; in_op = 4'hA;
    step();
    in_valid = 1'b0; in_zero = 1'b0; in_eq = 1'b0; in_op = '0;
    vectors++; if (zero_seen !== 1'b1 || carry_seen !== 1'b0) begin
      $display("FAIL sticky_zero got c=%0b z=%0b want c=0 z=1", carry_seen, zero_seen); miscompares++; end
    vectors++; if ({out_carry, out_zero, out_eq, out_op} !== 7'b0111010) begin
      $display("FAIL flags_carried got %b want 0111010", {out_carry, out_zero, out_eq, out_op}); miscompares++; end
    step();
    vectors++; if (zero_seen !== 1'b1) begin $display("FAIL sticky_hold got %0b want 1", zero_seen); miscompares++; end
  endtask

  task automatic test_count_wrap();
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1; in_f = 32'h1;
    repeat (65535) step();
    vectors++; if (acc_count !== 16'hFFFF) begin $display("FAIL count_max got %h want ffff", acc_count); miscompares++; end
    step();
    in_valid = 1'b0;
    vectors++; if (acc_count !== 16'h0000) begin $display("FAIL count_wrap got %h want 0000", acc_count); miscompares++; end
  endtask

  task automatic test_parity();
    logic exp_odd;
`ifdef ALU_RESULT_PARITY_EN
    exp_odd = 1'b1;
`else
    exp_odd = 1'b0;
`endif
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1; in_f = 32'h0000_0007;
    step();
    vectors++; if (out_parity !== exp_odd) begin $display("FAIL parity_7 got %0b want %0b", out_parity, exp_odd); miscompares++; end
    in_f = 32'h0000_0003;
    step();
    in_valid = 1'b0;
    vectors++; if (out_f !== 32'h3 || out_parity !== 1'b0) begin
      $display("FAIL parity_3 got f=%h p=%0b want 00000003 p=0", out_f, out_parity); miscompares++; end
  endtask

  task automatic test_reset_in_two();
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_f = 32'h11;
    step();
    in_f = 32'h22;
    step();
    vectors++; if (in_ready !== 1'b0) begin $display("FAIL two_ready got %0b want 0", in_ready); miscompares++; end
    rst = 1'b1; out_ready = 1'b1; sticky_clr = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sticky_clr = 1'b0;
    vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL two_reset got v=%0b r=%0b want v=0 r=1", out_valid, in_ready); miscompares++; end
    vectors++; if (acc_count !== 16'h0 || out_f !== 32'h0) begin
      $display("FAIL two_reset_data got cnt=%h f=%h want 0 0", acc_count, out_f); miscompares++; end
    out_ready = 1'b1;
    step();
    vectors++; if (out_valid !== 1'b0) begin $display("FAIL two_discard got %0b want 0", out_valid); miscompares++; end
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_sticky();
    test_count_wrap();
    test_parity();
    test_reset_in_two();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 Parameter WIDTH, default 32, sets the result datapath width.
REQ-002 Parameter CNT_W, default 16, sets the accepted-result counter width.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 in_valid  input  1  upstream ALU result is valid.
REQ-006 in_ready  output  1  stage can accept a result this cycle.
REQ-007 in_f  input  WIDTH  ALU result word F.
REQ-008 in_carry, in_zero, in_eq  input  1 each  ALU carry_out, zero_flag and eq_flag.
REQ-009 in_op  input  4  select code S that produced the result.
REQ-010 out_valid  output  1  buffered result is valid.
REQ-011 out_ready  input  1  downstream consumes the result.
REQ-012 out_f  output  WIDTH  buffered result word.
REQ-013 out_carry, out_zero, out_eq  output  1 each  buffered flags.
REQ-014 out_op  output  4  buffered select code.
REQ-015 out_parity  output  1  even parity of out_f (see Configuration).
REQ-016 sticky_clr  input  1  clears the sticky flags.
REQ-017 carry_seen, zero_seen  output  1 each  sticky flags.
REQ-018 acc_count  output  CNT_W  number of accepted results, modulo 2^CNT_W.

Function
REQ-019 The block SHALL be a 2-entry in-order buffer with states EMPTY, ONE and TWO, and SHALL keep each entry's {f, carry, zero, eq, op} together.
REQ-020 Accept SHALL occur when in_valid and in_ready are both 1; pop SHALL occur when out_valid and out_ready are both 1.
REQ-021 in_ready SHALL be a registered output equal to 1 in EMPTY and ONE, and 0 in TWO.
REQ-022 out_valid SHALL be 1 in ONE and TWO and SHALL present the oldest entry; outputs SHALL be driven from registers (latency: accept in cycle N gives visibility in cycle N+1).
REQ-023 Transitions: EMPTY+accept->ONE; ONE+accept+no pop->TWO; ONE+pop+no accept->EMPTY; ONE+accept+pop->ONE with the new entry at the head; TWO+pop->ONE; otherwise hold.
REQ-024 In TWO, in_valid SHALL be ignored, and no data SHALL be overwritten or dropped.
REQ-025 While out_valid=1 and out_ready=0, out_* SHALL hold stable.
REQ-026 acc_count SHALL increment by 1 on each accept and wrap from 2^CNT_W-1 to 0.
REQ-027 carry_seen (zero_seen) SHALL set on the cycle after an accept with in_carry=1 (in_zero=1).
REQ-028 sticky_clr SHALL clear both sticky flags on the next edge; if sticky_clr coincides with a setting accept, set SHALL win.
REQ-029 The buffer SHALL carry out_f unmodified and SHALL apply no arithmetic to it.

Reset
REQ-030 On rst=1 at a clock edge, state SHALL become EMPTY, and the following SHALL be 0: out_valid, out_f, out_carry, out_zero, out_eq, out_op, out_parity, carry_seen, zero_seen and acc_count; in_ready SHALL become 1.
REQ-031 rst SHALL override any simultaneous accept, pop or sticky_clr, and buffered entries in flight SHALL be discarded.

Configuration
REQ-032 Macro ALU_RESULT_PARITY_EN: when defined, out_parity SHALL be a registered value equal to the XOR of all bits of the head entry's f, updated with the entry.
REQ-033 When ALU_RESULT_PARITY_EN is undefined, out_parity SHALL be tied to 0 and no parity logic SHALL be built; the port list SHALL be unchanged.

Verification
REQ-034 Reset, then accept f=0x0000_0005 with out_ready=1 -> next cycle out_valid=1, out_f=0x5, and acc_count=1; following cycle out_valid=0.
REQ-035 With out_ready=0, accept 0xAAAA_0001 then 0xAAAA_0002 -> in_ready=0, and a third in_valid is ignored; raising out_ready pops 0x...01 then 0x...02 in order, and acc_count=2.
REQ-036 In ONE, simultaneous accept of 0x10 and pop -> state stays ONE, out_f=0x10 next cycle, and in_ready stays 1.
REQ-037 Accept with in_carry=1 while sticky_clr=1 -> carry_seen=1; a later sticky_clr with no accept -> carry_seen=0.
REQ-038 Preload acc_count to 0xFFFF by accepting 65535 results, then accept one more -> acc_count=0x0000.
REQ-039 With ALU_RESULT_PARITY_EN defined, accept f=0x0000_0007 -> out_parity=1; accept 0x0000_0003 -> out_parity=0; with the macro undefined -> out_parity=0 always; rst asserted in TWO -> EMPTY, out_valid=0 and in_ready=1 next cycle.
